// File: rtl/persp_proj_fx.sv
// persp_proj_fx: fixed-point perspective projection of one triangle per transaction with near clip and screen clamp
module persp_proj_fx #(
    parameter int N_VERT = 3,
    parameter int COORD_W = 16,
    parameter int FRAC = 8,
    parameter int FOCAL = 180,
    parameter int FOCAL_W = 8,
    parameter int SCREEN_W = 360,
    parameter int SCREEN_H = 360,
    parameter int OUT_W = 9,
    parameter logic [COORD_W-1:0] NEAR = 16'h0080
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             valid_in,
    output logic                             ready_in,
    input  logic                             obj_done_in,
    input  logic [N_VERT-1:0][COORD_W-1:0]   x_in,
    input  logic [N_VERT-1:0][COORD_W-1:0]   y_in,
    input  logic [N_VERT-1:0][COORD_W-1:0]   z_in,
    output logic                             valid_out,
    input  logic                             ready_out,
    output logic [N_VERT-1:0][OUT_W-1:0]     sx_out,
    output logic [N_VERT-1:0][OUT_W-1:0]     sy_out,
    output logic [N_VERT-1:0][OUT_W-1:0]     depth_out,
    output logic [N_VERT-1:0]                offscreen_out,
    output logic                             clip_out,
    output logic                             obj_done_out
);
    localparam int DQ = COORD_W + FOCAL_W;
    localparam int VW = (N_VERT > 1) ? $clog2(N_VERT) : 1;
    localparam int CW = $clog2(DQ);
    localparam logic [VW-1:0] LAST_V = VW'(N_VERT - 1);
    localparam logic signed [COORD_W-1:0] NEAR_S = NEAR;
    localparam logic signed [DQ+1:0] CX = (DQ+2)'(SCREEN_W / 2);
    localparam logic signed [DQ+1:0] CY = (DQ+2)'(SCREEN_H / 2);
    localparam logic signed [DQ+1:0] XMAX = (DQ+2)'(SCREEN_W - 1);
    localparam logic signed [DQ+1:0] YMAX = (DQ+2)'(SCREEN_H - 1);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, DIVX = 3'd2, DIVY = 3'd3, POST = 3'd4, OUT = 3'd5;

    logic [2:0] state;
    logic [N_VERT-1:0][COORD_W-1:0] x_r, y_r, z_r;
    logic od_r, any_near, ge, last;
    logic [VW-1:0] v, vn;
    logic [CW-1:0] cnt;
    logic [COORD_W-1:0] rem, rem_nx, xv, yv, zv, xn, zs;
    logic [COORD_W:0] rem_sh;
    logic [DQ-1:0] dq, dq_nx;
    logic signed [DQ+1:0] qx, qy, q_s, qx_fin, qy_fin, sx_t, sy_t;
    logic [OUT_W-1:0] sx_c, sy_c, dep_c;
    logic off_c;

    // FOCAL * |c| as the unsigned dividend; the sign is reapplied to the quotient
    function automatic logic [DQ-1:0] dividend(input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = c[COORD_W-1] ? -c : c;
        return DQ'(FOCAL) * DQ'(m);
    endfunction

    assign ready_in = state == IDLE;
    assign xv = x_r[v];
    assign yv = y_r[v];
    assign zv = z_r[v];
    assign vn = (v == LAST_V) ? '0 : v + 1'b1;
    assign xn = x_r[vn];

    // near-plane test over all latched vertices
    always_comb begin
        any_near = 1'b0;
        for (int i = 0; i < N_VERT; i++) any_near = any_near | ($signed(z_r[i]) < NEAR_S);
    end

    // one restoring-division step plus the projection, clamp and depth of the current vertex
    always_comb begin
        rem_sh = {rem, dq[DQ-1]};
        ge = rem_sh >= {1'b0, zv};
        rem_nx = ge ? COORD_W'(rem_sh - {1'b0, zv}) : rem_sh[COORD_W-1:0];
        dq_nx = {dq[DQ-2:0], ge};
        last = cnt == CW'(DQ - 1);
        q_s = $signed({2'b00, dq_nx});
        qx_fin = xv[COORD_W-1] ? -q_s : q_s;
        qy_fin = yv[COORD_W-1] ? -q_s : q_s;
        sx_t = CX + qx;
        sy_t = CY - qy;
        sx_c = (sx_t < 0) ? '0 : (sx_t > XMAX) ? XMAX[OUT_W-1:0] : sx_t[OUT_W-1:0];
        sy_c = (sy_t < 0) ? '0 : (sy_t > YMAX) ? YMAX[OUT_W-1:0] : sy_t[OUT_W-1:0];
        off_c = (sx_t < 0) || (sx_t > XMAX) || (sy_t < 0) || (sy_t > YMAX);
        zs = zv >> FRAC;
        dep_c = (zs > COORD_W'((2 ** OUT_W) - 1)) ? '1 : zs[OUT_W-1:0];
    end

    // control FSM, shared divider and result registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            valid_out <= 1'b0;
            sx_out <= '0;
            sy_out <= '0;
            depth_out <= '0;
            offscreen_out <= '0;
            clip_out <= 1'b0;
            obj_done_out <= 1'b0;
            od_r <= 1'b0;
            v <= '0;
            cnt <= '0;
            rem <= '0;
            dq <= '0;
            qx <= '0;
            qy <= '0;
        end else begin
            case (state)
                IDLE: if (valid_in) begin
                    x_r <= x_in;
                    y_r <= y_in;
                    z_r <= z_in;
                    od_r <= obj_done_in;
                    state <= LOAD;
                end
                LOAD: begin
                    sx_out <= '0;
                    sy_out <= '0;
                    depth_out <= '0;
                    offscreen_out <= '0;
                    v <= '0;
                    cnt <= '0;
                    rem <= '0;
                    dq <= dividend(x_r[0]);
                    clip_out <= any_near;
                    if (any_near) begin
                        valid_out <= 1'b1;
                        obj_done_out <= od_r;
                        state <= OUT;
                    end else begin
                        state <= DIVX;
                    end
                end
                DIVX: begin
                    rem <= rem_nx;
                    dq <= dq_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        qx <= qx_fin;
                        cnt <= '0;
                        rem <= '0;
                        dq <= dividend(yv);
                        state <= DIVY;
                    end
                end
                DIVY: begin
                    rem <= rem_nx;
                    dq <= dq_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        qy <= qy_fin;
                        cnt <= '0;
                        state <= POST;
                    end
                end
                POST: begin
                    sx_out[v] <= sx_c;
                    sy_out[v] <= sy_c;
                    depth_out[v] <= dep_c;
                    offscreen_out[v] <= off_c;
                    if (v == LAST_V) begin
                        valid_out <= 1'b1;
                        obj_done_out <= od_r;
                        state <= OUT;
                    end else begin
                        v <= vn;
                        rem <= '0;
                        dq <= dividend(xn);
                        state <= DIVX;
                    end
                end
                OUT: if (ready_out) begin
                    valid_out <= 1'b0;
                    obj_done_out <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_persp_proj_fx.sv
// tb_persp_proj_fx: table-driven check of projection, clamp, clip, latency, backpressure and reset abort
module tb_persp_proj_fx;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic valid_in = 1'b0;
    logic ready_in;
    logic obj_done_in = 1'b0;
    logic [2:0][15:0] x_in = '0, y_in = '0, z_in = '0;
    logic valid_out;
    logic ready_out = 1'b0;
    logic [2:0][8:0] sx_out, sy_out, depth_out;
    logic [2:0] offscreen_out;
    logic clip_out, obj_done_out;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0][15:0] x, y, z;
        logic od;
        logic [2:0][8:0] sx, sy, dp;
        logic [2:0] off;
        logic clip;
        int lat;
    } vec_t;
    vec_t tv[5];

    persp_proj_fx dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_in(ready_in),
        .obj_done_in(obj_done_in), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .valid_out(valid_out), .ready_out(ready_out), .sx_out(sx_out), .sy_out(sy_out),
        .depth_out(depth_out), .offscreen_out(offscreen_out), .clip_out(clip_out),
        .obj_done_out(obj_done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input int i);
        int n;
        n = 0;
        while (!ready_in && n < 50) begin
            @(posedge clk_in); #1;
            n++;
        end
        chk("ready_before_accept", ready_in, 1'b1);
        x_in = tv[i].x;
        y_in = tv[i].y;
        z_in = tv[i].z;
        obj_done_in = tv[i].od;
        valid_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        x_in = '1;
        y_in = '1;
        z_in = '0;
        obj_done_in = ~tv[i].od;
    endtask

    task automatic run(input int i, input int hold);
        int n;
        send(i);
        n = 0;
        while (!valid_out && n < 400) begin
            @(posedge clk_in); #1;
            n++;
        end
        chk($sformatf("latency[%0d]", i), n, tv[i].lat);
        chk($sformatf("sx[%0d]", i), sx_out, tv[i].sx);
        chk($sformatf("sy[%0d]", i), sy_out, tv[i].sy);
        chk($sformatf("depth[%0d]", i), depth_out, tv[i].dp);
        chk($sformatf("offscreen[%0d]", i), offscreen_out, tv[i].off);
        chk($sformatf("clip[%0d]", i), clip_out, tv[i].clip);
        chk($sformatf("obj_done[%0d]", i), obj_done_out, tv[i].od);
        chk($sformatf("ready_in_busy[%0d]", i), ready_in, 1'b0);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk_in); #1;
            chk("hold_valid", valid_out, 1'b1);
            chk("hold_ready_in", ready_in, 1'b0);
            chk("hold_data", {sx_out, sy_out, depth_out, offscreen_out, clip_out, obj_done_out},
                {tv[i].sx, tv[i].sy, tv[i].dp, tv[i].off, tv[i].clip, tv[i].od});
        end
        ready_out = 1'b1;
        @(posedge clk_in); #1;
        ready_out = 1'b0;
        chk($sformatf("valid_after_xfer[%0d]", i), valid_out, 1'b0);
        chk($sformatf("ready_after_xfer[%0d]", i), ready_in, 1'b1);
        chk($sformatf("obj_done_idle[%0d]", i), obj_done_out, 1'b0);
    endtask

    initial begin
        tv[0] = '{x: {16'h0001, 16'hFF00, 16'h0100}, y: {16'hFFFF, 16'h0000, 16'h0080},
                  z: {16'h0100, 16'h0200, 16'h0200}, od: 1'b1,
                  sx: {9'd180, 9'd90, 9'd270}, sy: {9'd180, 9'd180, 9'd135}, dp: {9'd1, 9'd2, 9'd2},
                  off: 3'b000, clip: 1'b0, lat: 148};
        tv[1] = '{x: {16'hFC00, 16'h0000, 16'h0400}, y: {16'h0400, 16'h0000, 16'h0000},
                  z: {16'h0100, 16'h7FFF, 16'h0100}, od: 1'b0,
                  sx: {9'd0, 9'd180, 9'd359}, sy: {9'd0, 9'd180, 9'd180}, dp: {9'd1, 9'd127, 9'd1},
                  off: 3'b101, clip: 1'b0, lat: 148};
        tv[2] = '{x: {16'h0100, 16'h0100, 16'h0100}, y: {16'h0100, 16'h0100, 16'h0100},
                  z: {16'h0200, 16'h0010, 16'h0200}, od: 1'b1,
                  sx: '0, sy: '0, dp: '0, off: 3'b000, clip: 1'b1, lat: 1};
        tv[3] = '{x: {16'h0000, 16'h0000, 16'h0000}, y: {16'h0000, 16'h0000, 16'h0000},
                  z: {16'h0200, 16'h0200, 16'hFF00}, od: 1'b0,
                  sx: '0, sy: '0, dp: '0, off: 3'b000, clip: 1'b1, lat: 1};
        tv[4] = '{x: {16'hFF00, 16'h0100, 16'h0040}, y: {16'h0100, 16'h0000, 16'hFFC0},
                  z: {16'h0100, 16'h0101, 16'h0080}, od: 1'b1,
                  sx: {9'd0, 9'd359, 9'd270}, sy: {9'd0, 9'd180, 9'd270}, dp: {9'd1, 9'd1, 9'd0},
                  off: 3'b000, clip: 1'b0, lat: 148};

        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_ready", ready_in, 1'b1);
        chk("rst_data", {sx_out, sy_out, depth_out, offscreen_out, clip_out, obj_done_out}, '0);

        for (int i = 0; i < 5; i++) run(i, (i == 0) ? 10 : 0);

        send(0);
        repeat (30) @(posedge clk_in);
        #1 rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        chk("midrst_valid", valid_out, 1'b0);
        chk("midrst_ready", ready_in, 1'b1);
        chk("midrst_data", {sx_out, sy_out, depth_out, offscreen_out, clip_out, obj_done_out}, '0);
        repeat (3) @(posedge clk_in);
        #1 chk("midrst_no_output", valid_out, 1'b0);
        run(1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/persp_proj_fx.md
Name: persp_proj_fx

Overview:
- Parametrised successor to the float triangle projector: perspective-projects a whole triangle of N_VERT vertices per transaction into screen space.
- Uses signed fixed-point inputs and one shared sequential restoring divider, so no vendor float IP is needed.
- Sits between the transform stage and the rasteriser, and adds full valid/ready backpressure, near-plane clipping, and screen-edge clamping with per-vertex offscreen flags.
- obj_done travels with its triangle.

Parameters:
- N_VERT, 3: vertices per transaction.
- COORD_W, 16: input coordinate width, signed two's complement.
- FRAC, 8: fractional bits of input coordinates.
- FOCAL, 180: projection scale in pixels, unsigned.
- FOCAL_W, 8: bit width of FOCAL; FOCAL must be < 2^FOCAL_W.
- SCREEN_W, 360: screen width in pixels.
- SCREEN_H, 360: screen height in pixels.
- OUT_W, 9: output pixel and depth width; requires SCREEN_W, SCREEN_H <= 2^OUT_W.
- NEAR, 16'h0080: near plane in input format; must be > 0.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- valid_in  in  1  input triangle valid
- ready_in  out  1  block can accept a triangle
- obj_done_in  in  1  last triangle of object; captured on accept
- x_in  in  N_VERT x COORD_W  vertex x, signed, FRAC fractional bits
- y_in  in  N_VERT x COORD_W  vertex y, signed, FRAC fractional bits
- z_in  in  N_VERT x COORD_W  vertex z, signed, FRAC fractional bits
- valid_out  out  1  result valid
- ready_out  in  1  downstream accepts result
- sx_out  out  N_VERT x OUT_W  screen x
- sy_out  out  N_VERT x OUT_W  screen y
- depth_out  out  N_VERT x OUT_W  integer depth
- offscreen_out  out  N_VERT  per-vertex clamp flag
- clip_out  out  1  triangle rejected by near plane
- obj_done_out  out  1  registered copy of captured obj_done_in

Behaviour:
- Reset (synchronous, rst_in high at posedge):
  - state=IDLE, valid_out=0, all data outputs and obj_done_out = 0, divider cleared.
  - Reset mid-operation aborts the transaction with no output.
- Handshake:
  - ready_in = (state==IDLE); accept when valid_in && ready_in.
  - valid_out is held, with all outputs stable, until ready_out is high. Transfer then occurs and the block returns to IDLE.
  - Inputs are latched at accept and need not be held afterwards.
- States: IDLE, LOAD, DIVX, DIVY, POST, OUT.
  - IDLE -> LOAD on accept.
  - LOAD: if any z < NEAR (signed compare), set clip_out=1, zero sx/sy/depth/offscreen, go to OUT. Otherwise set vertex index v=0 and go to DIVX.
  - DIVX: computes qx = (FOCAL*x[v]) / z[v] in DQ = COORD_W+FOCAL_W cycles, one quotient bit per cycle. Division is on magnitudes and the sign is applied after, so the result truncates toward zero. Then go to DIVY.
  - DIVY: same computation for qy, DQ cycles, then POST.
  - POST (1 cycle):
    - sx = SCREEN_W/2 + qx; sy = SCREEN_H/2 - qy. Compute in signed DQ+2 bits.
    - Clamp each to [0, dim-1]; offscreen[v]=1 if either coordinate clamped.
    - depth = z[v] >> FRAC, saturated to 2^OUT_W-1.
    - Write results to index v. If v==N_VERT-1, go to OUT with valid_out=1; else v++ and go to DIVX.
  - OUT: wait for ready_out, then go to IDLE.
- Latency from the accept edge to valid_out high:
  - Unclipped: 1 + N_VERT*(2*DQ+1) edges; 148 with defaults.
  - Clipped: 1 edge.
- Division by zero is impossible, because z >= NEAR > 0 is required to reach the divider.
- Throughput: one triangle in flight; no overlap between output hold and the next accept.
- obj_done_out reflects the accepted triangle's obj_done_in while valid_out is high; it is 0 when idle.

Test Plan:
- Basic projection, vertex (x=0x0100, y=0x0080, z=0x0200) -> sx=270, sy=135, depth=2, offscreen=0, clip_out=0. valid_out must rise exactly 148 edges after accept.
- Negative coordinates and truncation:
  - x=0xFF00 (-1.0), z=0x0200 -> sx=90.
  - x=0x0001, z=0x0100 -> qx=0, sx=180.
  - y=0xFFFF, z=0x0100 -> sy=180.
- Clamping, x=0x0400, z=0x0100 (qx=720) -> sx=359 with offscreen=1 for that vertex only. A vertex at z=0x7FFF with x=y=0 must give depth=127, sx=sy=180.
- Near clip, one vertex z=0x0010 with other vertices valid -> clip_out=1, all coordinates 0, valid_out 1 edge after accept, obj_done_out equal to the input value.
- Backpressure: hold ready_out=0 for 10 cycles after valid_out -> outputs and valid_out stable, ready_in=0. When ready_out=1, transfer occurs and ready_in is high on the next cycle. Back-to-back triangles must produce results in order.
- Reset mid-DIVY with rst_in for 1 cycle -> next cycle state IDLE, valid_out=0, ready_in=1. A new triangle then gives a correct result with no stale data.
